// File: rtl/uart_rx_unit_if.sv
// Consumer-side bundle of the UART receiver: byte handshake plus
// sticky error flags and their clear strobe.
interface uart_rx_unit_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       error_clear;
    logic       framing_error;
    logic       overrun_error;

    modport master (
        output rx_data,
        output rx_valid,
        output framing_error,
        output overrun_error,
        input  rx_ready,
        input  error_clear
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  framing_error,
        input  overrun_error,
        output rx_ready,
        output error_clear
    );
endinterface

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with one-deep holding register and sticky errors.
// Optional UART_RX_MIDBIT_VOTE_EN: 2-of-3 majority vote at each sample point.
module uart_rx_unit #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           uart_input_line,
    uart_rx_unit_if.master bus
);

    localparam int BAUD_TICKS = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_TICKS = BAUD_TICKS / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_TICKS - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_TICKS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    logic        sync1_q, sync2_q;
    logic        rx_s;
    logic        sample;
    logic [2:0]  state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        fe_q, fe_d;
    logic        oe_q, oe_d;
    logic        deliver;
    logic        fe_set;
    logic        oe_set;
    logic        xfer;

    assign rx_s = sync2_q;

`ifdef UART_RX_MIDBIT_VOTE_EN
    // vote_q holds rx_s from the two cycles before the sample point
    logic [1:0] vote_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= {vote_q[0], rx_s};
        end
    end

    assign sample = (rx_s & vote_q[0]) | (rx_s & vote_q[1])
                  | (vote_q[0] & vote_q[1]);
`else
    assign sample = rx_s;
`endif

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        deliver    = 1'b0;
        fe_set     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d    = S_START;
                    baud_cnt_d = '0;
                end
            end
            S_START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    if (sample) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {sample, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (sample) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = S_RECOVER;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_RECOVER: begin
                // hold off until the line returns high so a break cannot retrigger
                if (rx_s) begin
                    state_d    = S_IDLE;
                    baud_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                baud_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        xfer       = rx_valid_q & bus.rx_ready;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~xfer;
        oe_set     = 1'b0;
        if (deliver) begin
            if (!rx_valid_q || xfer) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                oe_set = 1'b1;
            end
        end
        fe_d = fe_set | (fe_q & ~bus.error_clear);
        oe_d = oe_set | (oe_q & ~bus.error_clear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            fe_q       <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            sync1_q    <= uart_input_line;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            fe_q       <= fe_d;
            oe_q       <= oe_d;
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.framing_error = fe_q;
    assign bus.overrun_error = oe_q;

endmodule

// File: doc/uart_rx_unit.md
Name: uart_rx_unit

Overview:
UART receiver that consumes the 8N1 serial stream produced by the UART transmit unit: start bit, 8 data bits LSB first, 1 stop bit, idle high. It is used on the loopback path and as the CPU-side receive channel. Each received byte is held in a one-deep holding register with a valid/ready handshake toward the MMIO/FIFO consumer. Sticky framing and overrun error flags are reported alongside the data.

Parameters:
CLOCK_FREQ, 50_000_000, clk frequency in Hz
BAUD_RATE, 115200, line rate in baud
BAUD_TICKS (localparam), CLOCK_FREQ/BAUD_RATE (integer divide, 434 at defaults), clocks per bit
HALF_TICKS (localparam), BAUD_TICKS/2 (integer divide), clocks from start detect to start-bit mid-point

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
uart_input_line  input  1  serial line, asynchronous to clk, idle high
rx_ready  input  1  consumer accepts rx_data this cycle
error_clear  input  1  single-cycle pulse; clears both sticky error flags
rx_data  output  8  received byte; stable while rx_valid=1
rx_valid  output  1  holding register full
framing_error  output  1  sticky; stop bit sampled as 0
overrun_error  output  1  sticky; byte completed while the holding register was full

Behaviour:
- Reset is asynchronous, active-high. On reset: rx_data=0, rx_valid=0, framing_error=0, overrun_error=0, both synchronizer flops=1, state=IDLE, baud_cnt=0, bit_cnt=0, shift register=0.
- Synchronizer: uart_input_line passes through 2 flops giving rx_s. All sampling uses rx_s, never the raw pin.
- Baud counter: baud_cnt, 16 bits, clears on every state change.
- State IDLE: when rx_s=0, go to START with baud_cnt=0.
- State START: baud_cnt increments each cycle. When baud_cnt==HALF_TICKS-1, sample the line.
  - Sample=1: false start; go to IDLE.
  - Sample=0: go to DATA with baud_cnt=0 and bit_cnt=0.
- State DATA: when baud_cnt==BAUD_TICKS-1, sample the line, shift the bit into the MSB (shift right, so bits land LSB first), clear baud_cnt, and increment bit_cnt. The sample with bit_cnt==7 moves to STOP.
- State STOP: when baud_cnt==BAUD_TICKS-1, sample the line.
  - Sample=1: deliver the byte (see below) and go to IDLE.
  - Sample=0: set framing_error, discard the byte, go to RECOVER.
- State RECOVER: wait for rx_s=1, then go to IDLE. This prevents a break condition or stuck-low line from retriggering reception.
- Delivery: on the cycle after a good stop sample, rx_data=byte and rx_valid=1.
- Handshake: a transfer occurs on a cycle where rx_valid=1 and rx_ready=1. rx_valid deasserts on the following cycle unless a new byte is delivered in that same cycle. rx_data must not change while rx_valid=1 without a transfer.
- Simultaneous transfer and delivery: the new byte loads, rx_valid stays 1, overrun_error is not set.
- Overrun: delivery while rx_valid=1 and no transfer that cycle. The new byte is dropped, rx_data keeps the old byte, overrun_error is set.
- Errors are sticky until error_clear. If error_clear and a new error occur in the same cycle, the set wins.
- Latency: rx_valid rises 2 (sync) + HALF_TICKS + 9*BAUD_TICKS + 1 cycles after the falling edge of uart_input_line, ±1 for synchronizer phase.
- Reset mid-frame aborts the frame immediately. No partial byte is delivered.

Optional Feature:
- Macro: UART_RX_MIDBIT_VOTE_EN.
- Defined: each sample point takes the majority of the rx_s values at baud_cnt target-2, target-1 and target. This rejects a single-cycle glitch.
- Undefined: single sample of rx_s at the target count. No vote registers are built.

Test Plan:
All tests use CLOCK_FREQ=1_000_000 and BAUD_RATE=100_000, so BAUD_TICKS=10 and HALF_TICKS=5.
1. Drive 8N1 frame 0x55 with rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0x55; framing_error=0 and overrun_error=0; latency matches the formula ±1.
2. Line pulsed low for 3 cycles, then high -> no rx_valid, state returns to IDLE; a following frame 0xA3 is received as 0xA3.
3. Frame 0x3C with stop bit driven 0, then line held low 40 cycles, then high, then frame 0x0F -> framing_error=1, no delivery of 0x3C, 0x0F received; error_clear -> framing_error=0.
4. Back-to-back frames 0x12 then 0x34 with rx_ready=0 -> rx_data=0x12, rx_valid=1, overrun_error=1. Raise rx_ready for one cycle -> rx_valid=0.
5. Frames 0x00 and 0xFF, with rx_ready asserted exactly on the delivery cycle of 0xFF while 0x00 is pending -> 0x00 transferred, 0xFF loaded, no overrun.
6. Assert rst during data bit 4 of frame 0xC6 -> all outputs reset; the next frame 0x81 is received correctly. With UART_RX_MIDBIT_VOTE_EN, a 1-cycle inverted glitch at a data sample point -> byte still correct.
